// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS pipeline with
// integrated load-use hazard detection, branch flush and downstream hold.
// Optional feature: define ID_EX_PERF_CNT_EN to add bubble_count and
// flush_count saturating performance counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        id_opcode,
    input  logic              id_reg_dst,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              hold,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic              ex_reg_dst,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_write_reg
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_count,
    output logic [31:0]       flush_count
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic idUsesRt;
    logic loadRegister;
    logic loadBubble;

    // Decide whether the decode instruction reads rt as a source operand
    always_comb begin
        // NOTE: the default assignment comes first so every path drives idUsesRt and no latch is inferred.
        idUsesRt = 1'b0;
        case (id_opcode)
            OP_RTYPE, OP_BEQ, OP_SW: idUsesRt = 1'b1;
            default:                 idUsesRt = 1'b0;
        endcase
    end

    // Load-use detection: a load in EX whose target feeds the decode instruction.
    // Built only from EX state and decode fields; flush and hold never reach it.
    assign hazard_stall = ex_valid & ex_mem_read & (ex_rt != '0) &
                          ((ex_rt == id_rs) | (idUsesRt & (ex_rt == id_rt)));

    // Flush overrides hold; otherwise hold freezes everything.
    assign loadRegister = flush | ~hold;
    // A squashed or stalled decode instruction enters EX as a bubble.
    assign loadBubble   = flush | hazard_stall;

    // Pipeline register: capture decode bundle, or insert a bubble with live data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            ex_valid      <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
        end else if (loadRegister) begin
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
            ex_imm       <= id_imm;
            ex_pc4       <= id_pc4;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_write_reg <= id_reg_dst ? id_rd : id_rt;
            if (loadBubble) begin
                ex_valid      <= 1'b0;
                ex_reg_dst    <= 1'b0;
                ex_branch     <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_alu_op     <= '0;
            end else begin
                ex_valid      <= 1'b1;
                ex_reg_dst    <= id_reg_dst;
                ex_branch     <= id_branch;
                ex_mem_read   <= id_mem_read;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_mem_write  <= id_mem_write;
                ex_alu_src    <= id_alu_src;
                ex_reg_write  <= id_reg_write;
                ex_alu_op     <= id_alu_op;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating counters: flush bubbles and hazard bubbles, frozen during hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (!hold) begin
            if (flush) begin
                if (flush_count != '1) flush_count <= flush_count + 32'd1;
            end else if (hazard_stall) begin
                if (bubble_count != '1) bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. Directed scenarios for
// reset, load-use, rt qualification, $zero, flush and hold, followed by random
// traffic, all compared against a transaction-level reference model.
// Counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct {
        logic [5:0]  opcode;
        logic        regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
        logic [3:0]  aluOp;
        logic [31:0] rsData, rtData, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic        flush, hold;
    } idIn_t;

    typedef struct {
        logic        valid;
        logic        regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
        logic [3:0]  aluOp;
        logic [31:0] rsData, rtData, imm, pc4;
        logic [4:0]  rs, rt, writeReg;
    } exState_t;

    logic clk = 1'b0;
    logic reset;
    idIn_t    cur;
    exState_t mdl;
    longint   mdlBubbles, mdlFlushes;
    int checks = 0;
    int errors = 0;

    logic              hazard_stall, ex_valid, ex_reg_dst, ex_branch, ex_mem_read;
    logic              ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [3:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_write_reg;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       bubble_count, flush_count;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .id_opcode(cur.opcode),
        .id_reg_dst(cur.regDst), .id_branch(cur.branch), .id_mem_read(cur.memRead),
        .id_mem_to_reg(cur.memToReg), .id_mem_write(cur.memWrite),
        .id_alu_src(cur.aluSrc), .id_reg_write(cur.regWrite), .id_alu_op(cur.aluOp),
        .id_rs_data(cur.rsData), .id_rt_data(cur.rtData), .id_imm(cur.imm),
        .id_pc4(cur.pc4), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .flush(cur.flush), .hold(cur.hold), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_count(bubble_count), .flush_count(flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rule: which instructions read rt, and when a load blocks decode
    function automatic logic modelHazard();
        logic usesRt;
        usesRt = (cur.opcode == 6'h00) || (cur.opcode == 6'h04) || (cur.opcode == 6'h2B);
        return mdl.valid && mdl.memRead && (mdl.rt != 5'd0) &&
               ((mdl.rt == cur.rs) || (usesRt && (mdl.rt == cur.rt)));
    endfunction

    function automatic void modelReset();
        mdl = '{valid: 1'b0, regDst: 1'b0, branch: 1'b0, memRead: 1'b0, memToReg: 1'b0,
                memWrite: 1'b0, aluSrc: 1'b0, regWrite: 1'b0, aluOp: 4'd0, rsData: 32'd0,
                rtData: 32'd0, imm: 32'd0, pc4: 32'd0, rs: 5'd0, rt: 5'd0, writeReg: 5'd0};
        mdlBubbles = 0;
        mdlFlushes = 0;
    endfunction

    // One clock edge of the pipeline described at transaction level
    function automatic void modelEdge(input logic haz);
        exState_t nxt;
        if (!cur.flush && cur.hold) return;
        nxt.rsData   = cur.rsData;
        nxt.rtData   = cur.rtData;
        nxt.imm      = cur.imm;
        nxt.pc4      = cur.pc4;
        nxt.rs       = cur.rs;
        nxt.rt       = cur.rt;
        nxt.writeReg = cur.regDst ? cur.rd : cur.rt;
        if (cur.flush || haz) begin
            nxt.valid = 0; nxt.regDst = 0; nxt.branch = 0; nxt.memRead = 0;
            nxt.memToReg = 0; nxt.memWrite = 0; nxt.aluSrc = 0; nxt.regWrite = 0;
            nxt.aluOp = 0;
            if (!cur.hold) begin
                if (cur.flush) mdlFlushes = (mdlFlushes >= 64'hFFFF_FFFF) ? mdlFlushes : mdlFlushes + 1;
                else           mdlBubbles = (mdlBubbles >= 64'hFFFF_FFFF) ? mdlBubbles : mdlBubbles + 1;
            end
        end else begin
            nxt.valid = 1; nxt.regDst = cur.regDst; nxt.branch = cur.branch;
            nxt.memRead = cur.memRead; nxt.memToReg = cur.memToReg;
            nxt.memWrite = cur.memWrite; nxt.aluSrc = cur.aluSrc;
            nxt.regWrite = cur.regWrite; nxt.aluOp = cur.aluOp;
        end
        mdl = nxt;
    endfunction

    task automatic checkOutputs(input string tag);
        check({tag, "_valid"},    32'(ex_valid),      32'(mdl.valid));
        check({tag, "_regdst"},   32'(ex_reg_dst),    32'(mdl.regDst));
        check({tag, "_branch"},   32'(ex_branch),     32'(mdl.branch));
        check({tag, "_memrd"},    32'(ex_mem_read),   32'(mdl.memRead));
        check({tag, "_mem2reg"},  32'(ex_mem_to_reg), 32'(mdl.memToReg));
        check({tag, "_memwr"},    32'(ex_mem_write),  32'(mdl.memWrite));
        check({tag, "_alusrc"},   32'(ex_alu_src),    32'(mdl.aluSrc));
        check({tag, "_regwr"},    32'(ex_reg_write),  32'(mdl.regWrite));
        check({tag, "_aluop"},    32'(ex_alu_op),     32'(mdl.aluOp));
        check({tag, "_rsdata"},   ex_rs_data,         mdl.rsData);
        check({tag, "_rtdata"},   ex_rt_data,         mdl.rtData);
        check({tag, "_imm"},      ex_imm,             mdl.imm);
        check({tag, "_pc4"},      ex_pc4,             mdl.pc4);
        check({tag, "_rs"},       32'(ex_rs),         32'(mdl.rs));
        check({tag, "_rt"},       32'(ex_rt),         32'(mdl.rt));
        check({tag, "_wreg"},     32'(ex_write_reg),  32'(mdl.writeReg));
`ifdef ID_EX_PERF_CNT_EN
        check({tag, "_bubcnt"},   bubble_count,       mdlBubbles[31:0]);
        check({tag, "_flcnt"},    flush_count,        mdlFlushes[31:0]);
`endif
    endtask

    // Check the combinational stall, take one edge, then check registered state
    task automatic step(input string tag);
        logic expHaz;
        #1;
        expHaz = modelHazard();
        check({tag, "_haz"}, 32'(hazard_stall), 32'(expHaz));
        @(posedge clk);
        modelEdge(expHaz);
        #1;
        checkOutputs(tag);
    endtask

    task automatic randInputs();
        logic [5:0] ops [5];
        ops = '{6'h00, 6'h04, 6'h2B, 6'h23, 6'h0A};
        cur.opcode   = ops[$urandom_range(0, 4)];
        cur.regDst   = 1'($urandom);
        cur.branch   = 1'($urandom);
        cur.memRead  = ($urandom_range(0, 2) == 0);
        cur.memToReg = 1'($urandom);
        cur.memWrite = 1'($urandom);
        cur.aluSrc   = 1'($urandom);
        cur.regWrite = 1'($urandom);
        cur.aluOp    = 4'($urandom);
        cur.rsData   = $urandom;
        cur.rtData   = $urandom;
        cur.imm      = $urandom;
        cur.pc4      = $urandom;
        cur.rs       = 5'($urandom_range(0, 3));
        cur.rt       = 5'($urandom_range(0, 3));
        cur.rd       = 5'($urandom_range(0, 31));
        cur.flush    = 1'b0;
        cur.hold     = 1'b0;
    endtask

    // lw $t, 0($s): load with rt as destination
    task automatic setLw(input logic [4:0] t);
        randInputs();
        cur.opcode = 6'h23; cur.memRead = 1; cur.memWrite = 0; cur.regWrite = 1;
        cur.regDst = 0; cur.rt = t; cur.rs = 5'd4;
    endtask

    task automatic setInstr(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d);
        randInputs();
        cur.opcode = op; cur.rs = s; cur.rt = t; cur.rd = d;
        cur.memRead = 0; cur.regWrite = 1; cur.regDst = (op == 6'h00);
    endtask

    initial begin
        logic [31:0] frozen;
        randInputs();
        reset = 1'b1;
        modelReset();
        #12;
        reset = 1'b0;
        checkOutputs("rst");
        check("rst_haz", 32'(hazard_stall), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation and mid-stall
        setInstr(6'h00, 5'd1, 5'd2, 5'd3);
        step("arst_pre");
        check("arst_pre_valid", 32'(ex_valid), 32'd1);
        setLw(5'd8);
        step("arst_lw");
        setInstr(6'h00, 5'd8, 5'd10, 5'd9);
        #1;
        check("arst_stall", 32'(hazard_stall), 32'd1);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutputs("arst");
        check("arst_haz", 32'(hazard_stall), 32'd0);
        #1;
        reset = 1'b0;
        step("arst_post");

        // Load-use on rs: one stall, one bubble, then the add is captured
        setLw(5'd8);
        step("lurs_lw");
        setInstr(6'h00, 5'd8, 5'd10, 5'd9);
        #1;
        check("lurs_stall", 32'(hazard_stall), 32'd1);
        step("lurs_bub");
        check("lurs_bub_valid", 32'(ex_valid), 32'd0);
        check("lurs_bub_regwr", 32'(ex_reg_write), 32'd0);
        step("lurs_add");
        check("lurs_add_rs", 32'(ex_rs), 32'd8);
        check("lurs_add_valid", 32'(ex_valid), 32'd1);

        // rt qualification: slti does not read rt, sw does
        setLw(5'd8);
        step("rtq_lw1");
        setInstr(6'h0A, 5'd3, 5'd8, 5'd0);
        #1;
        check("rtq_slti", 32'(hazard_stall), 32'd0);
        step("rtq_slti");
        setLw(5'd8);
        step("rtq_lw2");
        setInstr(6'h2B, 5'd4, 5'd8, 5'd0);
        cur.regWrite = 0; cur.memWrite = 1;
        #1;
        check("rtq_sw", 32'(hazard_stall), 32'd1);
        step("rtq_sw");

        // Load into $zero never stalls
        setLw(5'd0);
        step("zero_lw");
        setInstr(6'h00, 5'd0, 5'd0, 5'd5);
        #1;
        check("zero_haz", 32'(hazard_stall), 32'd0);
        step("zero_add");

        // Flush coinciding with a hazard yields a single bubble
        setLw(5'd8);
        step("flh_lw");
        setInstr(6'h00, 5'd8, 5'd8, 5'd9);
        cur.flush = 1;
        #1;
        check("flh_stall", 32'(hazard_stall), 32'd1);
        step("flh_bub");
        cur.flush = 0;
        #1;
        check("flh_nostall", 32'(hazard_stall), 32'd0);
        step("flh_next");
        check("flh_next_valid", 32'(ex_valid), 32'd1);

        // Hold for three cycles with changing inputs, then release
        setInstr(6'h00, 5'd1, 5'd2, 5'd3);
        step("hold_cap");
        frozen = ex_rs_data;
        for (int i = 0; i < 3; i++) begin
            randInputs();
            cur.hold = 1;
            step("hold");
            check("hold_frozen", ex_rs_data, frozen);
        end
        randInputs();
        step("hold_rel");
        check("hold_rel_data", ex_rs_data, cur.rsData);

        // Random traffic including flush, hold and frequent load-use pairs
        for (int i = 0; i < 400; i++) begin
            randInputs();
            cur.flush = ($urandom_range(0, 7) == 0);
            cur.hold  = ($urandom_range(0, 6) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
